// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial carry-lookahead adder sequencer.
package cla_serial_add_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIB_W = 4;

endpackage

// File: rtl/cla_serial_add_ctrl_cla.sv
// 4-bit carry-lookahead slice; purely combinational, reused once per nibble pass.
module cla_4bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p and cin, no ripple chain.
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ {c[3], c[2], c[1], cin};
    assign cout = c[4];

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single CLA slice,
// with valid/ready handshakes on both the operand and the result side.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// RUN     | one nibble pass per clock, LSB first, carry held in carry_q
// DONE    | result held on sum/cout/ovf with out_valid until consumed
module cla_serial_add_ctrl
    import cla_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic             carry_q,   carry_d;
    logic [IDX_W-1:0] nib_idx_q, nib_idx_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;

    logic [NIB_W-1:0] slice_a;
    logic [NIB_W-1:0] slice_b;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_cout;
    logic             last_nib;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (nib_idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*NIB_W +: NIB_W];
                slice_b = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    cla_4bit_adder u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign last_nib = (nib_idx_q == IDX_W'(NIB - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        nib_idx_d = nib_idx_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    nib_idx_d = '0;
                    sum_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (nib_idx_q == IDX_W'(i)) begin
                        sum_d[i*NIB_W +: NIB_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (last_nib) begin
                    cout_d  = slice_cout;
                    // slice_sum[MSB] is the final result sign bit on the last pass
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_sum[NIB_W-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end else begin
                    nib_idx_d = nib_idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            nib_idx_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            nib_idx_q <= nib_idx_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
